// File: rtl/uart_tx_fifo.sv
// Transmit-side byte FIFO between the host holding register and the UART transmitter.
// Optional sticky write-while-full flag enabled by defining UART_TX_FIFO_OVFL_EN.
module uart_tx_fifo #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        tx_hold_reg,
  input  logic              fifo_write_n,
  input  logic              fifo_read_tx,
  output logic [7:0]        tx_dout_reg,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [ADDR_W:0]   fifo_count,
  output logic              tx_overflow,
  input  logic              clr_ovfl
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = ADDR_W + 1;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              wr_en_c;
  logic              rd_en_c;
  logic [CNT_W-1:0]  count_nxt_c;

  // Acceptance uses the registered flags, so a byte is never read in the cycle it lands.
  always_comb begin
    wr_en_c     = ~fifo_write_n & ~fifo_full;
    rd_en_c     = ~fifo_read_tx & ~fifo_empty;
    count_nxt_c = fifo_count + CNT_W'(wr_en_c) - CNT_W'(rd_en_c);
  end

  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[wptr] <= tx_hold_reg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      tx_dout_reg <= 8'h00;
      fifo_count  <= '0;
      fifo_empty  <= 1'b1;
      fifo_full   <= 1'b0;
    end else begin
      if (wr_en_c) begin
        wptr <= wptr + ADDR_W'(1);
      end
      if (rd_en_c) begin
        rptr        <= rptr + ADDR_W'(1);
        tx_dout_reg <= mem[rptr];
      end
      fifo_count <= count_nxt_c;
      fifo_empty <= (count_nxt_c == CNT_W'(0));
      fifo_full  <= (count_nxt_c == CNT_W'(DEPTH));
    end
  end

`ifdef UART_TX_FIFO_OVFL_EN
  // Set has priority over clear so a same-cycle overflow is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_overflow <= 1'b0;
    end else if (~fifo_write_n & fifo_full) begin
      tx_overflow <= 1'b1;
    end else if (clr_ovfl) begin
      tx_overflow <= 1'b0;
    end
  end
`else
  logic unused_clr_ovfl;
  assign unused_clr_ovfl = clr_ovfl;
  assign tx_overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: queue model drives expectations, a monitor checks read data.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_hold_reg;
  logic       fifo_write_n;
  logic       fifo_read_tx;
  logic [7:0] tx_dout_reg;
  logic       fifo_empty;
  logic       fifo_full;
  logic [4:0] fifo_count;
  logic       tx_overflow;
  logic       clr_ovfl;

  int checks = 0;
  int failures = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] exp_dout = 8'h00;
  bit         ovfl_m = 1'b0;
  bit         rd_flag = 1'b0;
  bit         pend = 1'b0;

  uart_tx_fifo #(.ADDR_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_hold_reg  (tx_hold_reg),
    .fifo_write_n (fifo_write_n),
    .fifo_read_tx (fifo_read_tx),
    .tx_dout_reg  (tx_dout_reg),
    .fifo_empty   (fifo_empty),
    .fifo_full    (fifo_full),
    .fifo_count   (fifo_count),
    .tx_overflow  (tx_overflow),
    .clr_ovfl     (clr_ovfl)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_status();
    chk("count", 32'(fifo_count), 32'(mq.size()));
    chk("empty", 32'(fifo_empty), 32'(mq.size() == 0));
    chk("full", 32'(fifo_full), 32'(mq.size() == 16));
    chk("ovfl", 32'(tx_overflow), 32'(ovfl_m));
  endtask

  // One clock of stimulus; the model queue decides what the DUT must accept.
  task automatic step(input bit wr, input logic [7:0] d, input bit rd, input bit clr);
    bit full_m;
    bit empty_m;
    full_m       = (mq.size() == 16);
    empty_m      = (mq.size() == 0);
    fifo_write_n = ~wr;
    tx_hold_reg  = d;
    fifo_read_tx = ~rd;
    clr_ovfl     = clr;
    rd_flag      = rd && !empty_m;
    if (rd_flag) exp_q.push_back(mq.pop_front());
    if (wr && !full_m) mq.push_back(d);
`ifdef UART_TX_FIFO_OVFL_EN
    if (wr && full_m) ovfl_m = 1'b1;
    else if (clr) ovfl_m = 1'b0;
`endif
    @(posedge clk);
    #1;
    fifo_write_n = 1'b1;
    fifo_read_tx = 1'b1;
    clr_ovfl     = 1'b0;
    rd_flag      = 1'b0;
    chk_status();
  endtask

  // Monitor: a read accepted at an edge must show its byte by the following negedge.
  initial forever begin
    @(posedge clk);
    pend = rd_flag && !reset;
  end

  initial forever begin
    @(negedge clk);
    if (reset) begin
      exp_dout = 8'h00;
    end else begin
      if (pend) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_underflow: read seen with no expected byte at %0t", $time);
        end else begin
          exp_dout = exp_q.pop_front();
        end
      end
      chk("dout", 32'(tx_dout_reg), 32'(exp_dout));
    end
  end

  initial begin
    reset        = 1'b1;
    tx_hold_reg  = 8'h00;
    fifo_write_n = 1'b1;
    fifo_read_tx = 1'b1;
    clr_ovfl     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_empty", 32'(fifo_empty), 32'd1);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_dout", 32'(tx_dout_reg), 32'h00);
    chk("rst_ovfl", 32'(tx_overflow), 32'd0);
    reset = 1'b0;

    // Single byte through, first write right after reset release.
    step(1, 8'hA5, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("a5_dout", 32'(tx_dout_reg), 32'hA5);

    // Read while empty leaves the output alone.
    step(0, 8'h00, 1, 0);

    // Fill, overflow, set-beats-clear, clear, drain.
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    chk("fill_count", 32'(fifo_count), 32'd16);
    step(1, 8'hFF, 0, 0);
    step(0, 8'h00, 0, 0);
    step(1, 8'hEE, 0, 1);
    step(0, 8'h00, 0, 1);
    // Write+read while full: read only.
    step(1, 8'hDD, 1, 0);
    step(1, 8'h10, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 1);

    // Wrap: 40 bytes with occupancy held in 1..3.
    step(1, 8'h40, 0, 0);
    step(1, 8'h41, 0, 0);
    for (int i = 2; i < 40; i++) step(1, 8'(8'h40 + i), 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("wrap_dout", 32'(tx_dout_reg), 32'h67);

    // Simultaneous write/read at count=5 holds count.
    for (int i = 0; i < 5; i++) step(1, 8'(8'h80 + i), 0, 0);
    for (int i = 0; i < 4; i++) step(1, 8'(8'h90 + i), 1, 0);
    chk("sim_count", 32'(fifo_count), 32'd5);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("sim_last", 32'(tx_dout_reg), 32'h93);
    // Same stimulus when empty: write only.
    step(1, 8'hC7, 1, 0);
    chk("empty_wr_count", 32'(fifo_count), 32'd1);
    step(0, 8'h00, 0, 0);
    chk("empty_wr_dout", 32'(tx_dout_reg), 32'h93);

    // Async reset mid-read with count=9.
    for (int i = 0; i < 9; i++) step(1, 8'(8'hB0 + i), 0, 0);
    step(0, 8'h00, 1, 0);
    step(1, 8'hB9, 0, 0);
    fifo_read_tx = 1'b0;
    #2;
    reset = 1'b1;
    exp_q.delete();
    mq.delete();
    ovfl_m = 1'b0;
    #1;
    chk("arst_count", 32'(fifo_count), 32'd0);
    chk("arst_empty", 32'(fifo_empty), 32'd1);
    chk("arst_full", 32'(fifo_full), 32'd0);
    chk("arst_dout", 32'(tx_dout_reg), 32'h00);
    fifo_read_tx = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1, 8'h5A, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);
    chk("post_rst_dout", 32'(tx_dout_reg), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter: ADDR_W, default 4, log2 of FIFO depth (DEPTH = 2**ADDR_W = 16 entries).
REQ-002 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: tx_hold_reg  input  8  byte to write, sampled when fifo_write_n=0.
REQ-005 Port: fifo_write_n  input  1  active-low write strobe, one byte per clk while low.
REQ-006 Port: fifo_read_tx  input  1  active-low read strobe from the transmitter, one byte per clk while low.
REQ-007 Port: tx_dout_reg  output  8  registered read data, feeds the transmitter byte load.
REQ-008 Port: fifo_empty  output  1  registered, 1 when occupancy is 0.
REQ-009 Port: fifo_full  output  1  registered, 1 when occupancy is DEPTH.
REQ-010 Port: fifo_count  output  ADDR_W+1  registered occupancy, 0..DEPTH.
REQ-011 Port: tx_overflow  output  1  sticky write-while-full flag (see Configuration).
REQ-012 Port: clr_ovfl  input  1  active-high, one-clk clear of tx_overflow.

Function
REQ-013 Storage SHALL be a DEPTH x 8 register array with ADDR_W-bit write pointer, read pointer and ADDR_W+1-bit occupancy counter; both pointers wrap DEPTH-1 -> 0.
REQ-014 Write accepted iff fifo_write_n=0 and fifo_full=0 (pre-edge value): store at wptr, wptr+1.
REQ-015 Read accepted iff fifo_read_tx=0 and fifo_empty=0 (pre-edge value): tx_dout_reg <= mem[rptr] at that edge, rptr+1.
REQ-016 Read latency: tx_dout_reg valid exactly 1 clk after the read edge; held unchanged until the next accepted read.
REQ-017 Write while full: byte discarded; no pointer or count change.
REQ-018 Read while empty: ignored; tx_dout_reg unchanged.
REQ-019 Simultaneous accepted write and read: both performed; count unchanged.
REQ-020 Simultaneous write and read when empty: write only; a byte is never read in the cycle it is written.
REQ-021 Simultaneous write and read when full: read only; write discarded and counted as overflow.
REQ-022 fifo_empty, fifo_full and fifo_count SHALL reflect post-edge occupancy in the cycle after the edge; no combinational paths from inputs to outputs.
REQ-023 FIFO order SHALL be strict first-in, first-out across pointer wrap.

Reset
REQ-024 When reset=1: wptr=0, rptr=0, fifo_count=0, fifo_empty=1, fifo_full=0, tx_dout_reg=8'h00, tx_overflow=0; this takes effect immediately, without waiting for clk.
REQ-025 Reset mid-operation discards all stored bytes; memory contents need no reset.
REQ-026 After reset deasserts, the first accepted write SHALL be possible on the next clk edge.

Configuration
REQ-027 Macro: UART_TX_FIFO_OVFL_EN.
REQ-028 If UART_TX_FIFO_OVFL_EN is defined: tx_overflow is set on any edge where fifo_write_n=0 and fifo_full=1, and stays set until clr_ovfl=1 or reset. If set and clear occur in the same cycle, set wins.
REQ-029 If UART_TX_FIFO_OVFL_EN is undefined: tx_overflow is tied to 0, clr_ovfl is ignored, and no overflow register is built.

Verification
REQ-030 Reset, then write 8'hA5 for 1 clk: next cycle fifo_empty=0, fifo_count=1; pulse fifo_read_tx low for 1 clk -> next cycle tx_dout_reg=8'hA5, fifo_empty=1.
REQ-031 Write 16 bytes 8'h00..8'h0F: fifo_full=1, fifo_count=16; a 17th write of 8'hFF -> count stays 16 and tx_overflow=1 (macro on) or 0 (macro off); then 16 reads return 8'h00..8'h0F in order.
REQ-032 Wrap: write/read 40 bytes of an incrementing pattern while keeping occupancy at 1..3 -> data order preserved and pointers wrap twice.
REQ-033 With count=5, hold write and read low together for 4 clks -> count stays 5 and reads return the oldest 4 bytes; with count=0, the same stimulus for 1 clk -> count=1 and tx_dout_reg unchanged.
REQ-034 Assert reset with count=9 mid-read -> outputs immediately show empty=1, count=0, tx_dout_reg=8'h00, with no clk edge required.
REQ-035 Transmitter loop: connect to the async transmitter in FIFO mode, write 8'h55 and 8'hC3 -> line carries both frames back-to-back in order with no duplicate or dropped byte.
